// File: rtl/alu_sout_deserializer_if.sv
// -----------------------------------------------------------------------------
// alu_sout_deserializer_if
//
// Purpose:
//   Bundles the ALU serial output line with the decoded packet record that
//   alu_sout_deserializer produces from it.
//
// Signals:
//   sout         serial line from the ALU, idles high
//   out_valid    one-cycle strobe, a complete packet was decoded
//   result_type  2'b01 correct-result packet, 2'b10 error packet
//   C            32-bit result word, first DATA byte is the MSB
//   alu_flags    {carry, overflow, zero, negative}
//   crc3b        CRC3 field as received
//   err_flags    error field as received (two copies of {data, crc, op})
//   parity       parity bit of the error packet as received
//   crc_ok       integrity check result of the last packet
//   frame_error  one-cycle strobe on any protocol violation
//
// Modports:
//   master  line driver / record consumer (ALU side plus checking stage)
//   slave   the deserializer: consumes sout, produces the record
// -----------------------------------------------------------------------------
interface alu_sout_deserializer_if;
    logic        sout;
    logic        out_valid;
    logic [1:0]  result_type;
    logic [31:0] C;
    logic [3:0]  alu_flags;
    logic [2:0]  crc3b;
    logic [5:0]  err_flags;
    logic        parity;
    logic        crc_ok;
    logic        frame_error;

    modport master (
        output sout,
        input  out_valid,
        input  result_type,
        input  C,
        input  alu_flags,
        input  crc3b,
        input  err_flags,
        input  parity,
        input  crc_ok,
        input  frame_error
    );

    modport slave (
        input  sout,
        output out_valid,
        output result_type,
        output C,
        output alu_flags,
        output crc3b,
        output err_flags,
        output parity,
        output crc_ok,
        output frame_error
    );
endinterface

// File: rtl/alu_sout_deserializer.sv
// -----------------------------------------------------------------------------
// alu_sout_deserializer
//
// Purpose:
//   Receiver on the ALU serial output line. Reassembles 11-bit frames
//   (start 0, type, d[7:0], stop 1; MSB first) into ALU response packets:
//     correct-result packet : 4 DATA frames (C MSB first) + CTL with d[7]=0
//     error packet          : a single CTL frame with d[7]=1
//   Each packet is presented as one parallel record with a single-cycle
//   out_valid strobe. Malformed traffic (bad stop bit, unexpected frame type
//   or order, inter-frame timeout) raises a single-cycle frame_error.
//
// Parameters:
//   TIMEOUT_CYCLES  idle-high cycles tolerated between frames of an open
//                   packet before the packet is aborted (default 64)
//
// Ports:
//   clk    system clock, sout sampled once per rising edge
//   rst_n  asynchronous active-low reset
//   bus    alu_sout_deserializer_if.slave (sout in, decoded record out)
//
// Configuration:
//   ALU_DES_CRC_CHECK_EN  when defined, crc_ok carries the result of a CRC3
//                         check (correct packets) or a parity check (error
//                         packets). When undefined, crc_ok is tied to 1.
// -----------------------------------------------------------------------------
module alu_sout_deserializer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_sout_deserializer_if.slave  bus
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [1:0] RT_CORRECT = 2'b01;
    localparam logic [1:0] RT_ERROR   = 2'b10;

    localparam int              TW            = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]    state_q,       state_d;
    logic [3:0]    bit_cnt_q,     bit_cnt_d;
    logic [9:0]    shift_q,       shift_d;
    logic [2:0]    byte_cnt_q,    byte_cnt_d;
    logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;

    // Output record registers
    logic          out_valid_q,   out_valid_d;
    logic          frame_error_q, frame_error_d;
    logic [1:0]    result_type_q, result_type_d;
    logic [31:0]   c_q,           c_d;
    logic [3:0]    alu_flags_q,   alu_flags_d;
    logic [2:0]    crc3b_q,       crc3b_d;
    logic [5:0]    err_flags_q,   err_flags_d;
    logic          parity_q,      parity_d;

    // Partially assembled result word, separate from the published C so
    // that C only changes together with out_valid.
    logic [3:0]    lane_we;
    logic [31:0]   c_acc;

    // Captured frame fields: shift_q holds {type, d[7:0], stop}
    logic          f_type;
    logic [7:0]    f_data;
    logic          f_stop;

    assign f_type = shift_q[9];
    assign f_data = shift_q[8:1];
    assign f_stop = shift_q[0];

    // Timeout expiry is evaluated before the start-bit check in IDLE, so a
    // start bit coinciding with expiry aborts the old packet and still opens
    // a fresh frame.
    logic timeout_hit;
    assign timeout_hit = (state_q == ST_IDLE) && (byte_cnt_q != 3'd0) &&
                         (timeout_cnt_q == TIMEOUT_LIMIT);

`ifdef ALU_DES_CRC_CHECK_EN
    logic crc_ok_q, crc_ok_d;

    // CRC3, polynomial x^3 + x + 1, init 3'b000, MSB first, no final xor.
    function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
        logic [2:0] r;
        logic       fb;
        r = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = r[2] ^ msg[i];
            r  = {r[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
        end
        return r;
    endfunction

    logic correct_crc_match;
    logic error_par_match;

    assign correct_crc_match = (f_data[2:0] == crc3_calc({c_acc, 1'b0, f_data[6:3]}));
    assign error_par_match   = (f_data[0] == ^{1'b1, f_data[6:1]});
`endif

    // -------------------------------------------------------------------------
    // Result word byte lanes. Lane gi holds C[31-8*gi -: 8]; it is written by
    // the DATA frame received while byte_cnt == gi.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_q <= 8'h00;
                end else if (lane_we[gi]) begin
                    lane_q <= f_data;
                end
            end

            assign c_acc[31-8*gi -: 8] = lane_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic: bit FSM, packet assembler, timeout
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        byte_cnt_d    = byte_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        lane_we       = 4'b0000;

        out_valid_d   = 1'b0;
        frame_error_d = 1'b0;
        result_type_d = result_type_q;
        c_d           = c_q;
        alu_flags_d   = alu_flags_q;
        crc3b_d       = crc3b_q;
        err_flags_d   = err_flags_q;
        parity_d      = parity_q;
`ifdef ALU_DES_CRC_CHECK_EN
        crc_ok_d      = crc_ok_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (timeout_hit) begin
                    frame_error_d = 1'b1;
                    byte_cnt_d    = 3'd0;
                    timeout_cnt_d = '0;
                end else if ((byte_cnt_q != 3'd0) && bus.sout) begin
                    timeout_cnt_d = timeout_cnt_q + TW'(1);
                end

                if (!bus.sout) begin
                    state_d       = ST_SHIFT;
                    bit_cnt_d     = 4'd1;
                    timeout_cnt_d = '0;
                end
            end

            ST_SHIFT: begin
                shift_d   = {shift_q[8:0], bus.sout};
                bit_cnt_d = bit_cnt_q + 4'd1;
                // bit_cnt counts the start bit as 1, so the stop bit is the
                // one sampled while bit_cnt == 10.
                if (bit_cnt_q == 4'd10) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                state_d = ST_IDLE;

                if (!f_stop) begin
                    frame_error_d = 1'b1;
                    byte_cnt_d    = 3'd0;
                end else if (!f_type) begin
                    // DATA frame
                    if (byte_cnt_q < 3'd4) begin
                        lane_we[byte_cnt_q[1:0]] = 1'b1;
                        byte_cnt_d               = byte_cnt_q + 3'd1;
                    end else begin
                        frame_error_d = 1'b1;
                        byte_cnt_d    = 3'd0;
                    end
                end else if ((byte_cnt_q == 3'd0) && f_data[7]) begin
                    // Error packet: C, alu_flags and crc3b keep their values
                    out_valid_d   = 1'b1;
                    result_type_d = RT_ERROR;
                    err_flags_d   = f_data[6:1];
                    parity_d      = f_data[0];
`ifdef ALU_DES_CRC_CHECK_EN
                    crc_ok_d      = error_par_match;
`endif
                end else if ((byte_cnt_q == 3'd4) && !f_data[7]) begin
                    // Correct-result packet: err_flags and parity keep values
                    out_valid_d   = 1'b1;
                    result_type_d = RT_CORRECT;
                    c_d           = c_acc;
                    alu_flags_d   = f_data[6:3];
                    crc3b_d       = f_data[2:0];
                    byte_cnt_d    = 3'd0;
`ifdef ALU_DES_CRC_CHECK_EN
                    crc_ok_d      = correct_crc_match;
`endif
                end else begin
                    frame_error_d = 1'b1;
                    byte_cnt_d    = 3'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 10'd0;
            byte_cnt_q    <= 3'd0;
            timeout_cnt_q <= '0;
            out_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            result_type_q <= 2'b00;
            c_q           <= 32'h0;
            alu_flags_q   <= 4'h0;
            crc3b_q       <= 3'h0;
            err_flags_q   <= 6'h0;
            parity_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            byte_cnt_q    <= byte_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            out_valid_q   <= out_valid_d;
            frame_error_q <= frame_error_d;
            result_type_q <= result_type_d;
            c_q           <= c_d;
            alu_flags_q   <= alu_flags_d;
            crc3b_q       <= crc3b_d;
            err_flags_q   <= err_flags_d;
            parity_q      <= parity_d;
        end
    end

`ifdef ALU_DES_CRC_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_ok_q <= 1'b1;
        end else begin
            crc_ok_q <= crc_ok_d;
        end
    end

    assign bus.crc_ok = crc_ok_q;
`else
    assign bus.crc_ok = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.out_valid   = out_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.result_type = result_type_q;
    assign bus.C           = c_q;
    assign bus.alu_flags   = alu_flags_q;
    assign bus.crc3b       = crc3b_q;
    assign bus.err_flags   = err_flags_q;
    assign bus.parity      = parity_q;

endmodule

// File: tb/tb_alu_sout_deserializer.sv
module tb_alu_sout_deserializer;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n;

    alu_sout_deserializer_if bus_if ();

    alu_sout_deserializer #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  rtype;
        logic [31:0] c;
        logic [3:0]  flags;
        logic [2:0]  crc3b;
        logic [5:0]  errf;
        logic        parity;
        logic        crc_ok;
    } rec_t;

    localparam rec_t RESET_REC = {2'b00, 32'h0, 4'h0, 3'h0, 6'h0, 1'b0, 1'b1};

`ifdef ALU_DES_CRC_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    rec_t exp_q[$];
    rec_t cur;
    int   errors    = 0;
    int   checks    = 0;
    int   valid_cnt = 0;
    int   ferr_cnt  = 0;

    // CRC3 reference: remainder of (msg * x^3) divided by x^3 + x + 1
    function automatic logic [2:0] model_crc(input logic [36:0] msg);
        logic [39:0] r;
        r = {msg, 3'b000};
        for (int i = 39; i >= 3; i--) begin
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        end
        return r[2:0];
    endfunction

    function automatic rec_t observed();
        rec_t r;
        r = {bus_if.result_type, bus_if.C, bus_if.alu_flags, bus_if.crc3b,
             bus_if.err_flags, bus_if.parity, bus_if.crc_ok};
        return r;
    endfunction

    // Scoreboard: every out_valid pops one expected record
    always @(negedge clk) begin
        if (rst_n && bus_if.out_valid) begin
            rec_t e;
            rec_t g;
            valid_cnt++;
            checks++;
            g = observed();
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid got=%h expected no packet", g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL packet_record got=%h expected=%h", g, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_if.frame_error) ferr_cnt++;
    end

    // ---------------------------------------------------------------- drivers
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_if.sout = 1'b1;
        end
    endtask

    task automatic send_frame(input logic ftype, input logic [7:0] d,
                              input logic stop, input int gap);
        logic [10:0] bits;
        bits = {1'b0, ftype, d, stop};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            bus_if.sout = bits[i];
        end
        idle(gap);
    endtask

    task automatic send_correct(input logic [31:0] c, input logic [3:0] flags,
                                input logic flip);
        logic [2:0] crc;
        crc = model_crc({c, 1'b0, flags}) ^ {2'b00, flip};
        cur.rtype  = 2'b01;
        cur.c      = c;
        cur.flags  = flags;
        cur.crc3b  = crc;
        cur.crc_ok = CHECK_EN ? !flip : 1'b1;
        exp_q.push_back(cur);
        for (int b = 0; b < 4; b++) send_frame(1'b0, c[31-8*b -: 8], 1'b1, 2);
        send_frame(1'b1, {1'b0, flags, crc}, 1'b1, 2);
        $display("tx correct C=%h flags=%b crc3b=%b", c, flags, crc);
    endtask

    task automatic send_error(input logic [6:0] low);
        cur.rtype  = 2'b10;
        cur.errf   = low[6:1];
        cur.parity = low[0];
        cur.crc_ok = CHECK_EN ? (low[0] == ^{1'b1, low[6:1]}) : 1'b1;
        exp_q.push_back(cur);
        send_frame(1'b1, {1'b1, low}, 1'b1, 2);
        $display("tx error d=%h", {1'b1, low});
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rec_t g;
        rst_n = 1'b0;
        bus_if.sout = 1'b1;
        repeat (3) @(negedge clk);
        g = observed();
        checks++;
        if (g !== RESET_REC) begin
            errors++;
            $display("FAIL reset_record got=%h expected=%h", g, RESET_REC);
        end
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.frame_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%b%b expected=00",
                     bus_if.out_valid, bus_if.frame_error);
        end
        rst_n = 1'b1;
        cur = RESET_REC;
        idle(3);
        g = observed();
        checks++;
        if (g !== RESET_REC) begin
            errors++;
            $display("FAIL reset_release got=%h expected=%h", g, RESET_REC);
        end
        $display("test_reset done");
    endtask

    task automatic test_correct_packet();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_correct(32'h0000_0003, 4'b0000, 1'b0);
        idle(3);
        checks++;
        if (valid_cnt - v0 !== 1 || ferr_cnt - f0 !== 0) begin
            errors++;
            $display("FAIL correct_counts valid=%0d ferr=%0d expected 1 0",
                     valid_cnt - v0, ferr_cnt - f0);
        end
    endtask

    task automatic test_error_packet();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_error(7'h49);  // frame byte 0xC9: err_flags 100100, parity 1
        idle(3);
        checks++;
        if (valid_cnt - v0 !== 1 || ferr_cnt - f0 !== 0) begin
            errors++;
            $display("FAIL error_counts valid=%0d ferr=%0d expected 1 0",
                     valid_cnt - v0, ferr_cnt - f0);
        end
    endtask

    task automatic test_bad_stop();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(1'b0, 8'h5A, 1'b0, 2);
        idle(3);
        checks++;
        if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL bad_stop valid=%0d ferr=%0d expected 0 1",
                     valid_cnt - v0, ferr_cnt - f0);
        end
        $display("tx bad stop frame");
        v0 = valid_cnt;
        send_correct(32'hDEAD_BEEF, 4'b1010, 1'b0);
        idle(3);
        checks++;
        if (valid_cnt - v0 !== 1) begin
            errors++;
            $display("FAIL bad_stop_recover valid=%0d expected 1", valid_cnt - v0);
        end
    endtask

    task automatic test_timeout();
        int v0, f0, f_mid;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(1'b0, 8'h11, 1'b1, 2);
        send_frame(1'b0, 8'h22, 1'b1, 2);
        idle(TIMEOUT - 6);
        f_mid = ferr_cnt;
        idle(16);
        checks++;
        if (f_mid - f0 !== 0) begin
            errors++;
            $display("FAIL timeout_early ferr=%0d expected 0", f_mid - f0);
        end
        checks++;
        if (ferr_cnt - f0 !== 1 || valid_cnt - v0 !== 0) begin
            errors++;
            $display("FAIL timeout_pulse ferr=%0d valid=%0d expected 1 0",
                     ferr_cnt - f0, valid_cnt - v0);
        end
        $display("tx two DATA frames then idle timeout");
        v0 = valid_cnt; f0 = ferr_cnt;
        send_correct(32'hA5C3_0F81, 4'b0110, 1'b0);
        idle(3);
        checks++;
        if (valid_cnt - v0 !== 1 || ferr_cnt - f0 !== 0) begin
            errors++;
            $display("FAIL timeout_recover valid=%0d ferr=%0d expected 1 0",
                     valid_cnt - v0, ferr_cnt - f0);
        end
    endtask

    task automatic test_reset_mid_packet();
        int v0, f0;
        logic [6:0] part;
        rec_t g;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(1'b0, 8'h77, 1'b1, 2);
        send_frame(1'b0, 8'h88, 1'b1, 2);
        part = 7'b0_0_1001_1;  // start, type, first data bits of the third frame
        for (int i = 6; i >= 0; i--) begin
            @(negedge clk);
            bus_if.sout = part[i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus_if.sout = 1'b1;
        @(negedge clk);
        g = observed();
        checks++;
        if (g !== RESET_REC || bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_record got=%h valid=%b expected=%h valid=0",
                     g, bus_if.out_valid, RESET_REC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cur = RESET_REC;
        idle(15);
        checks++;
        if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin
            errors++;
            $display("FAIL reset_mid_strobes valid=%0d ferr=%0d expected 0 0",
                     valid_cnt - v0, ferr_cnt - f0);
        end
        $display("tx reset during third DATA frame");
        v0 = valid_cnt;
        send_correct(32'h0102_0304, 4'b1001, 1'b0);
        idle(3);
        checks++;
        if (valid_cnt - v0 !== 1) begin
            errors++;
            $display("FAIL reset_mid_recover valid=%0d expected 1", valid_cnt - v0);
        end
    endtask

    task automatic test_bad_crc();
        int v0;
        v0 = valid_cnt;
        send_correct(32'h5555_AAAA, 4'b0011, 1'b1);
        idle(3);
        checks++;
        if (valid_cnt - v0 !== 1) begin
            errors++;
            $display("FAIL bad_crc_valid valid=%0d expected 1", valid_cnt - v0);
        end
    endtask

    task automatic test_protocol();
        int v0, f0;
        rec_t g;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(1'b1, 8'h05, 1'b1, 2);        // correct-type CTL with no data
        idle(3);
        checks++;
        if (ferr_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL ctl_order ferr=%0d expected 1", ferr_cnt - f0);
        end
        for (int b = 0; b < 5; b++) send_frame(1'b0, 8'(8'h30 + b), 1'b1, 2);
        idle(3);
        checks++;
        if (ferr_cnt - f0 !== 2 || valid_cnt - v0 !== 0) begin
            errors++;
            $display("FAIL fifth_data ferr=%0d valid=%0d expected 2 0",
                     ferr_cnt - f0, valid_cnt - v0);
        end
        g = observed();
        checks++;
        if (g !== cur) begin
            errors++;
            $display("FAIL record_hold got=%h expected=%h", g, cur);
        end
        $display("tx protocol violations");
    endtask

    task automatic test_back_to_back();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_correct(32'h1234_5678, 4'b0101, 1'b0);
        send_error(7'h2B);
        send_correct(32'hFFFF_FFFF, 4'b1111, 1'b0);
        send_error(7'h7F);
        idle(4);
        checks++;
        if (valid_cnt - v0 !== 4 || ferr_cnt - f0 !== 0) begin
            errors++;
            $display("FAIL back_to_back valid=%0d ferr=%0d expected 4 0",
                     valid_cnt - v0, ferr_cnt - f0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.sout = 1'b1;
        cur = RESET_REC;
        test_reset();
        test_correct_packet();
        test_error_packet();
        test_bad_stop();
        test_timeout();
        test_reset_mid_packet();
        test_bad_crc();
        test_protocol();
        test_back_to_back();
        idle(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
